// File: rtl/fpu_config_loader_multi.sv
// Fetches an image/filter configuration block one word per request and
// presents it to the FPU address generators and MAC array.
module fpu_config_loader_multi #(
  parameter int FILTER_DIM  = 3,
  parameter int NUM_FILTERS = 1,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        load_config_start,
  input  logic [ADDR_W-1:0]                           config_base_addr,
  output logic [ADDR_W-1:0]                           address_mem,
  output logic                                        mem_req,
  input  logic                                        mapped_data_valid,
  input  logic [DATA_W-1:0]                           data_mem,
  output logic [15:0]                                 image_width,
  output logic [15:0]                                 image_height,
  output logic [ADDR_W-1:0]                           start_address,
  output logic [ADDR_W-1:0]                           result_address,
  output logic [NUM_FILTERS*FILTER_DIM*FILTER_DIM*8-1:0] filter,
  output logic                                        busy,
  output logic                                        load_config_done,
  output logic                                        config_valid,
  output logic                                        config_error
);
  localparam int NB    = NUM_FILTERS * FILTER_DIM * FILTER_DIM;
  localparam int NCW   = (NB + 3) / 4;
  localparam int NW    = 3 + NCW;
  localparam int IDX_W = $clog2(NW);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NW - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             cap;
  logic             cfg_bad;

  assign cap = (state == FETCH) && mapped_data_valid;

  // Header words are all captured before the first coefficient word, so the
  // registered fields are final by the time the last word lands.
  assign cfg_bad = (image_width == 16'd0) || (image_height == 16'd0) ||
                   (start_address[1:0] != 2'b00) || (result_address[1:0] != 2'b00) ||
                   (start_address == result_address);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      address_mem      <= '0;
      mem_req          <= 1'b0;
      busy             <= 1'b0;
      load_config_done <= 1'b0;
      config_valid     <= 1'b0;
      config_error     <= 1'b0;
      image_width      <= '0;
      image_height     <= '0;
      start_address    <= '0;
      result_address   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_config_start) begin
            idx          <= '0;
            address_mem  <= config_base_addr;
            mem_req      <= 1'b1;
            busy         <= 1'b1;
            config_valid <= 1'b0;
            config_error <= 1'b0;
            state        <= FETCH;
          end
        end
        FETCH: begin
          if (mapped_data_valid) begin
            if (idx == IDX_W'(0)) begin
              image_width  <= data_mem[15:0];
              image_height <= data_mem[31:16];
            end
            if (idx == IDX_W'(1)) start_address  <= ADDR_W'(data_mem);
            if (idx == IDX_W'(2)) result_address <= ADDR_W'(data_mem);
            if (idx == LAST_IDX) begin
              mem_req          <= 1'b0;
              busy             <= 1'b0;
              load_config_done <= 1'b1;
              config_valid     <= 1'b1;
              config_error     <= cfg_bad;
              state            <= DONE;
            end else begin
              idx         <= idx + IDX_W'(1);
              address_mem <= address_mem + ADDR_W'(4);
            end
          end
        end
        DONE: begin
          load_config_done <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One lane per coefficient word; the last lane keeps only the bytes that
  // belong to the filter image and drops the padding bytes.
  for (genvar c = 0; c < NCW; c++) begin : g_coef
    localparam int NBY = ((NB - 4*c) >= 4) ? 4 : (NB - 4*c);
    logic [NBY*8-1:0] coef;

    always_ff @(posedge clk) begin
      if (rst)                                coef <= '0;
      else if (cap && idx == IDX_W'(3 + c))   coef <= data_mem[NBY*8-1:0];
    end

    assign filter[c*32 +: NBY*8] = coef;
  end

endmodule

// File: tb/tb_fpu_config_loader_multi.sv
// Randomized scoreboard bench: a K=3/NF=1 instance and a K=5/NF=2 instance
// share a clock; a memory responder feeds each, a monitor checks outputs.
module tb_fpu_config_loader_multi;
  typedef struct packed {
    logic [15:0]  width;
    logic [15:0]  height;
    logic [31:0]  sa;
    logic [31:0]  ra;
    logic         err;
    logic [399:0] filt;
  } cfg_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start [2];
  logic [31:0]  base_in [2];
  logic         vld [2];
  logic [31:0]  dat [2];
  logic [31:0]  addr [2];
  logic         req [2];
  logic [15:0]  wid [2];
  logic [15:0]  hgt [2];
  logic [31:0]  sa [2];
  logic [31:0]  ra [2];
  logic         bsy [2];
  logic         done [2];
  logic         cv [2];
  logic         ce [2];
  logic [71:0]  filt0;
  logic [399:0] filt1;
  logic [399:0] filt [2];

  assign filt[0] = {328'b0, filt0};
  assign filt[1] = filt1;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [bit [32:0]];
  logic [31:0] aq [2][$];
  cfg_t        exp_q [2][$];
  int          wmode [2];
  int          cnt [2];
  int          curw [2];
  logic [31:0] paddr [2];
  bit          pwait [2];

  always #5 clk = ~clk;

  fpu_config_loader_multi #(.FILTER_DIM(3), .NUM_FILTERS(1)) dut0 (
    .clk(clk), .rst(rst), .load_config_start(start[0]), .config_base_addr(base_in[0]),
    .address_mem(addr[0]), .mem_req(req[0]), .mapped_data_valid(vld[0]), .data_mem(dat[0]),
    .image_width(wid[0]), .image_height(hgt[0]), .start_address(sa[0]), .result_address(ra[0]),
    .filter(filt0), .busy(bsy[0]), .load_config_done(done[0]), .config_valid(cv[0]),
    .config_error(ce[0]));

  fpu_config_loader_multi #(.FILTER_DIM(5), .NUM_FILTERS(2)) dut1 (
    .clk(clk), .rst(rst), .load_config_start(start[1]), .config_base_addr(base_in[1]),
    .address_mem(addr[1]), .mem_req(req[1]), .mapped_data_valid(vld[1]), .data_mem(dat[1]),
    .image_width(wid[1]), .image_height(hgt[1]), .start_address(sa[1]), .result_address(ra[1]),
    .filter(filt1), .busy(bsy[1]), .load_config_done(done[1]), .config_valid(cv[1]),
    .config_error(ce[1]));

  function automatic int nw(int d);
    return (d != 0) ? 16 : 6;
  endfunction

  function automatic int nb(int d);
    return (d != 0) ? 50 : 9;
  endfunction

  function automatic bit [32:0] key(int d, logic [31:0] a);
    return {d[0], a};
  endfunction

  function automatic logic [31:0] rd(int d, logic [31:0] a);
    if (mem.exists(key(d, a))) return mem[key(d, a)];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic int pick(int d);
    return (wmode[d] < 0) ? int'($urandom_range(0, 3)) : wmode[d];
  endfunction

  task automatic chk(string name, logic [399:0] act, logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // Memory responder: per request waits curw cycles, then presents data.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!req[d]) begin
        vld[d]  = 1'b0;
        cnt[d]  = 0;
        curw[d] = pick(d);
      end else begin
        if (vld[d]) begin
          cnt[d]  = 0;
          curw[d] = pick(d);
        end
        if (cnt[d] >= curw[d]) begin
          vld[d] = 1'b1;
          dat[d] = rd(d, addr[d]);
        end else begin
          vld[d] = 1'b0;
          dat[d] = $urandom;
          cnt[d]++;
        end
      end
    end
  end

  // Monitor: request addresses, hold-during-wait, and completed configs.
  always begin
    @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      if (req[d] && !rst) begin
        if (vld[d]) begin
          if (aq[d].size() == 0) fail("extra_request");
          else chk("req_addr", 400'(addr[d]), 400'(aq[d].pop_front()));
          pwait[d] = 1'b0;
        end else begin
          if (pwait[d]) chk("hold_addr", 400'(addr[d]), 400'(paddr[d]));
          pwait[d] = 1'b1;
          paddr[d] = addr[d];
        end
      end else begin
        if (pwait[d] && !rst) chk("hold_req", 400'(req[d]), 400'(1));
        pwait[d] = 1'b0;
      end
      if (done[d]) begin
        if (exp_q[d].size() == 0) fail("unexpected_done");
        else begin
          cfg_t e;
          e = exp_q[d].pop_front();
          chk("width",  400'(wid[d]), 400'(e.width));
          chk("height", 400'(hgt[d]), 400'(e.height));
          chk("start_address",  400'(sa[d]), 400'(e.sa));
          chk("result_address", 400'(ra[d]), 400'(e.ra));
          chk("filter", filt[d], e.filt);
          chk("flags_err_valid_busy", 400'({ce[d], cv[d], bsy[d]}), 400'({e.err, 1'b1, 1'b0}));
        end
      end
    end
  end

  task automatic fill(int d, logic [31:0] base, logic [31:0] w0, logic [31:0] w1, logic [31:0] w2);
    mem[key(d, base)]               = w0;
    mem[key(d, base + 32'd4)]       = w1;
    mem[key(d, base + 32'd8)]       = w2;
    for (int i = 3; i < nw(d); i++) mem[key(d, base + 32'(4*i))] = $urandom;
  endtask

  // Reference: read the block as the memory holds it and apply the layout rules.
  task automatic expect_load(int d, logic [31:0] base, bit with_cfg);
    cfg_t e;
    logic [31:0] w;
    for (int i = 0; i < nw(d); i++) aq[d].push_back(base + 32'(4*i));
    w        = rd(d, base);
    e.width  = w[15:0];
    e.height = w[31:16];
    e.sa     = rd(d, base + 32'd4);
    e.ra     = rd(d, base + 32'd8);
    e.filt   = '0;
    for (int j = 0; j < nb(d); j++) begin
      w = rd(d, base + 32'(4 * (3 + j/4)));
      e.filt[8*j +: 8] = w[8*(j%4) +: 8];
    end
    e.err = (e.width == 0) || (e.height == 0) || (e.sa[1:0] != 0) || (e.ra[1:0] != 0) ||
            (e.sa == e.ra);
    if (with_cfg) exp_q[d].push_back(e);
  endtask

  task automatic load(int d, logic [31:0] base, int wm, int lat, int extra_at, int rst_at);
    int n;
    bit got;
    wmode[d] = wm;
    expect_load(d, base, rst_at < 0);
    @(negedge clk);
    start[d]   = 1'b1;
    base_in[d] = base;
    @(negedge clk);
    start[d]   = 1'b0;
    base_in[d] = $urandom;
    n   = 0;
    got = 1'b0;
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      start[d] = 1'b0;
      if (n == rst_at) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_outputs", 400'({addr[d], wid[d], hgt[d], sa[d], ra[d], req[d], bsy[d],
                                 done[d], cv[d], ce[d]}), 400'(0));
        chk("rst_filter", filt[d], 400'(0));
        aq[d].delete();
        repeat (3) @(negedge clk);
        return;
      end
      if (done[d]) got = 1'b1;
      else if (n == extra_at) begin
        start[d]   = 1'b1;
        base_in[d] = base ^ 32'h0000_0100;
      end
    end
    if (!got) begin
      fail("done_timeout");
      return;
    end
    if (lat >= 0) chk("latency", 400'(n), 400'(lat));
    chk("request_count_left", 400'(aq[d].size()), 400'(0));
    aq[d].delete();
    // A start while in DONE must be ignored.
    if (extra_at >= 0) start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
    chk("after_done", 400'({done[d], cv[d], bsy[d], req[d]}), 400'(4'b0100));
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; base_in[d] = '0; vld[d] = 1'b0; dat[d] = '0;
      wmode[d] = 0; cnt[d] = 0; curw[d] = 0; pwait[d] = 1'b0; paddr[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("reset_outputs", 400'({addr[d], wid[d], hgt[d], sa[d], ra[d], req[d], bsy[d],
                                 done[d], cv[d], ce[d]}), 400'(0));
      chk("reset_filter", filt[d], 400'(0));
    end

    // Reference block: 320x240, filter bytes 1..9.
    fill(0, 32'h1000, 32'h00F0_0140, 32'h2000, 32'h8000);
    mem[key(0, 32'h100C)] = 32'h0403_0201;
    mem[key(0, 32'h1010)] = 32'h0807_0605;
    mem[key(0, 32'h1014)] = 32'hAABB_CC09;
    load(0, 32'h1000, 0, 6, -1, -1);
    chk("t1_filter_const", filt[0], 400'(72'h09_0807_0605_0403_0201));
    chk("t1_size_const", 400'({hgt[0], wid[0]}), 400'(32'h00F0_0140));
    load(0, 32'h1000, 2, 18, -1, -1);

    // K=5, NF=2: 16 words, last word's top two bytes dropped.
    fill(1, 32'h4000, 32'h0010_0020, 32'h1_0000, 32'h2_0000);
    load(1, 32'h4000, 0, 16, -1, -1);
    chk("t3_bank1_byte0", 400'(filt[1][207:200]), 400'(rd(1, 32'h4024) >> 8 & 32'hFF));

    // Illegal configurations.
    fill(0, 32'h3000, 32'h0000_0140, 32'h2000, 32'h8000);
    load(0, 32'h3000, 0, 6, -1, -1);
    chk("t4_err_height", 400'(ce[0]), 400'(1));
    fill(0, 32'h3000, 32'h00F0_0140, 32'h2002, 32'h8000);
    load(0, 32'h3000, 1, 12, -1, -1);
    chk("t4_err_unaligned", 400'(ce[0]), 400'(1));
    fill(0, 32'h3000, 32'h00F0_0140, 32'h2000, 32'h2000);
    load(0, 32'h3000, 0, 6, -1, -1);
    chk("t4_err_same", 400'(ce[0]), 400'(1));

    // Start while busy is ignored; rst mid-fetch discards the load.
    fill(0, 32'h5000, 32'h0008_0008, 32'h100, 32'h200);
    load(0, 32'h5000, 0, 6, 3, -1);
    fill(1, 32'h6000, 32'h0008_0008, 32'h100, 32'h200);
    load(1, 32'h6000, -1, -1, 3, -1);
    load(0, 32'h5000, 0, -1, -1, 4);
    load(0, 32'h5000, 0, 6, -1, -1);

    // Randomized loads, including wrap-around bases and illegal fields.
    for (int it = 0; it < 24; it++) begin
      int d, wm, sel;
      logic [31:0] base, w0, w1, w2;
      d    = int'($urandom_range(0, 1));
      base = $urandom & 32'hFFFF_FFFC;
      if ((it % 6) == 5) base = 32'hFFFF_FFF0;
      w0   = $urandom;
      w1   = $urandom & 32'hFFFF_FFFC;
      w2   = $urandom & 32'hFFFF_FFFC;
      sel  = int'($urandom_range(0, 7));
      if (sel == 0) w0 = w0 & 32'hFFFF_0000;
      if (sel == 1) w1 = w1 | 32'h1;
      if (sel == 2) w2 = w1;
      wm   = int'($urandom_range(0, 3)) - 1;
      fill(d, base, w0, w1, w2);
      load(d, base, wm, (wm >= 0) ? nw(d) * (1 + wm) : -1, -1, -1);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/fpu_config_loader_multi.md
Name: fpu_config_loader_multi

Overview:
- Parametrised successor of the FPU config loader.
- On a start pulse, it fetches an image/filter configuration block from memory-mapped space, one word per request.
- It supports KxK filters, multiple filter banks and a runtime base address, and it flags illegal configurations.
- It sits between the host-mapped config region and the FPU datapath. Its outputs feed the FPU's address generators and MAC array.

Parameters:
- FILTER_DIM, 3, filter side length K (K*K coefficients per bank, 8 bits each, K >= 1).
- NUM_FILTERS, 1, number of filter banks loaded back-to-back.
- ADDR_W, 32, address width.
- DATA_W, 32, memory data width; fixed at 32 (4 coefficient bytes per word).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- load_config_start  in  1  single-cycle start pulse.
- config_base_addr  in  ADDR_W  base of config block; sampled on an accepted start.
- address_mem  out  ADDR_W  word address of the current request.
- mem_req  out  1  request valid; held until data returns.
- mapped_data_valid  in  1  data_mem holds the response for the current request.
- data_mem  in  DATA_W  read data.
- image_width  out  16  image width.
- image_height  out  16  image height.
- start_address  out  ADDR_W  source image base.
- result_address  out  ADDR_W  destination base.
- filter  out  NUM_FILTERS*FILTER_DIM*FILTER_DIM*8  coefficients. Byte j sits at bits [8j+7:8j]. Bank b starts at byte b*K*K.
- busy  out  1  fetch in progress.
- load_config_done  out  1  one-cycle completion pulse.
- config_valid  out  1  outputs hold a complete configuration.
- config_error  out  1  last load was illegal; valid with config_valid.

Behaviour:
- Config block layout, word offsets from config_base_addr, byte address = base + 4*i:
  - w0: [15:0] width, [31:16] height.
  - w1: start_address.
  - w2: result_address.
  - w3 onward: coefficient bytes, little-endian (byte 0 = data[7:0]).
- Word count:
  - NB = NUM_FILTERS*K*K bytes.
  - NW = 3 + ceil(NB/4).
  - Unused bytes of the last word are discarded.
- Reset values: every output 0, state IDLE, word index 0.
- FSM states and transitions:
  - IDLE → FETCH when load_config_start=1.
    - Latch config_base_addr.
    - Clear idx, config_valid and config_error.
    - Set busy.
  - FETCH:
    - mem_req=1 and address_mem = base + 4*idx.
    - On a cycle with mapped_data_valid=1: capture data_mem into the field for idx and increment idx.
    - When idx = NW-1 is captured, go to DONE.
    - Otherwise stay in FETCH, presenting the next address on the following cycle.
    - While mapped_data_valid=0, mem_req and address_mem are held stable.
  - DONE, one cycle:
    - load_config_done=1, config_valid=1, busy=0.
    - config_error is set and return to IDLE.
- Only one request is outstanding at a time. mapped_data_valid is ignored outside FETCH.
- Latency with a zero-wait memory (valid same cycle as mem_req):
  - Start sampled at edge 0.
  - Words are captured at edges 1..NW.
  - load_config_done is high in the cycle after edge NW.
  - Each wait cycle adds one cycle.
- config_error=1 if any of:
  - width==0 or height==0;
  - start_address[1:0]≠0 or result_address[1:0]≠0;
  - start_address==result_address.
- Output fields update as words arrive. Consumers qualify them with config_valid.
- A start pulse while busy, or in DONE, is ignored. A start in IDLE in the same cycle done just fell is accepted normally.
- rst mid-fetch:
  - Next edge returns to IDLE with all outputs zero.
  - No done pulse; the partial configuration is discarded.
- Address arithmetic wraps modulo 2^ADDR_W.

Test Plan:
1. K=3, NF=1, base 0x1000, zero-wait memory returning w0=0x00F0_0140, w1=0x2000, w2=0x8000, w3..w5=0x04030201, 0x08070605, 0xAABBCC09 → six requests at 0x1000..0x1014. Result: width=320, height=240, filter bytes 1..9, done pulse at cycle 7, config_valid=1, config_error=0.
2. Same config with 2 wait cycles before each valid → mem_req and address held stable during waits. Done at cycle 19, same outputs.
3. K=5, NF=2 (NB=50, NW=16) → bytes 50 and 51 of the last word are dropped. Bank 1 byte 0 lands at filter[207:200]. Exactly 16 requests are issued.
4. Illegal configs, each with otherwise legal values:
   - w0=0x0000_0140 (height 0) → config_error=1.
   - w1=0x2002 (unaligned) → config_error=1.
   - w1==w2 → config_error=1.
   - done and config_valid still asserted in each case.
5. Second start pulse at cycle 3 of a load → ignored. NW requests total, one done pulse.
6. rst asserted at cycle 4 of a load → next cycle all outputs 0 and mem_req=0, no done. A fresh start afterwards completes normally.
